// File: rtl/masked_rf_pkg.sv
// Shared types for the masked-share register file: opcodes, FSM states, share vector.
package masked_rf_pkg;

    localparam int DEF_DATA_W     = 64;
    localparam int DEF_NUM_SHARES = 2;

    typedef enum logic [2:0] {
        OP_WRITE   = 3'd0,
        OP_READ    = 3'd1,
        OP_SWAP    = 3'd2,
        OP_XOR     = 3'd3,
        OP_REFRESH = 3'd4,
        OP_CLEAR   = 3'd5
    } op_e;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        S_XOR     = 3'd1,
        S_REFRESH = 3'd2,
        S_CLEAR   = 3'd3,
        S_DONE    = 3'd4
    } state_e;

    typedef logic [DEF_NUM_SHARES-1:0][DEF_DATA_W-1:0] share_t;

endpackage

// File: rtl/masked_share_refresh.sv
// Combinational remasking of one Boolean-shared word; the XOR of all shares is preserved
// because the last share absorbs the XOR of every randomness word applied to the others.
module masked_share_refresh #(
    parameter int DATA_W     = 64,
    parameter int NUM_SHARES = 2
) (
    input  logic [NUM_SHARES*DATA_W-1:0]     shares,
    input  logic [(NUM_SHARES-1)*DATA_W-1:0] rnd,
    output logic [NUM_SHARES*DATA_W-1:0]     remasked
);

    logic [DATA_W-1:0] acc;

    always_comb begin
        remasked = shares;
        acc      = '0;
        for (int s = 0; s < NUM_SHARES - 1; s++) begin
            remasked[s*DATA_W +: DATA_W] = shares[s*DATA_W +: DATA_W] ^ rnd[s*DATA_W +: DATA_W];
            acc = acc ^ rnd[s*DATA_W +: DATA_W];
        end
        remasked[(NUM_SHARES-1)*DATA_W +: DATA_W] =
            shares[(NUM_SHARES-1)*DATA_W +: DATA_W] ^ acc;
    end

endmodule

// File: rtl/masked_share_rf.sv
// Sequenced register file of Boolean-masked entries; multi-entry ops walk one entry per cycle.
// Single-cycle ops finish via S_DONE, so at most one command is accepted every two cycles.
module masked_share_rf
    import masked_rf_pkg::*;
#(
    parameter int DATA_W     = 64,
    parameter int NUM_REGS   = 16,
    parameter int NUM_SHARES = 2,
    parameter int AW         = $clog2(NUM_REGS),
    parameter int LW         = AW + 1
) (
    input  logic                             clk_i,
    input  logic                             rst_i,
    input  logic                             req_valid_i,
    output logic                             req_ready_o,
    input  logic [2:0]                       op_i,
    input  logic [AW-1:0]                    rd_i,
    input  logic [AW-1:0]                    rs1_i,
    input  logic [AW-1:0]                    rs2_i,
    input  logic [LW-1:0]                    len_i,
    input  logic [NUM_SHARES*DATA_W-1:0]     wdata_i,
    input  logic [(NUM_SHARES-1)*DATA_W-1:0] rnd_i,
    input  logic                             rnd_valid_i,
    output logic                             rnd_ready_o,
    output logic [NUM_SHARES*DATA_W-1:0]     rdata0_o,
    output logic [NUM_SHARES*DATA_W-1:0]     rdata1_o,
    output logic                             done_o,
    output logic                             busy_o
);

    localparam int EW = NUM_SHARES * DATA_W;

    logic [EW-1:0] mem [NUM_REGS];
    state_e        state_q;
    logic [AW-1:0] cnt_q, last_q, rd_q, rs1_q;
    logic [AW-1:0] dst, src;
    logic [LW-1:0] len_eff;
    logic [EW-1:0] refreshed;

    assign len_eff = (len_i > LW'(NUM_REGS)) ? LW'(NUM_REGS) : len_i;
    // Address arithmetic is AW bits wide, so base+i wraps modulo NUM_REGS for free.
    assign dst = rd_q + cnt_q;
    assign src = rs1_q + cnt_q;

    assign req_ready_o = (state_q == IDLE) && !rst_i;
    assign rnd_ready_o = (state_q == S_REFRESH);
    assign done_o      = (state_q == S_DONE);
    assign busy_o      = (state_q != IDLE);

    masked_share_refresh #(
        .DATA_W     (DATA_W),
        .NUM_SHARES (NUM_SHARES)
    ) u_refresh (
        .shares   (mem[dst]),
        .rnd      (rnd_i),
        .remasked (refreshed)
    );

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            last_q   <= '0;
            rd_q     <= '0;
            rs1_q    <= '0;
            rdata0_o <= '0;
            rdata1_o <= '0;
            for (int i = 0; i < NUM_REGS; i++) begin
                mem[i] <= '0;
            end
        end else begin
            case (state_q)
                IDLE: begin
                    if (req_valid_i) begin
                        rd_q    <= rd_i;
                        rs1_q   <= rs1_i;
                        cnt_q   <= '0;
                        last_q  <= len_eff[AW-1:0] - AW'(1);
                        state_q <= S_DONE;
                        case (op_i)
                            OP_WRITE: mem[rd_i] <= wdata_i;
                            OP_READ: begin
                                rdata0_o <= mem[rs1_i];
                                rdata1_o <= mem[rs2_i];
                            end
                            OP_SWAP: begin
                                mem[rs1_i] <= mem[rs2_i];
                                mem[rs2_i] <= mem[rs1_i];
                            end
                            OP_XOR: begin
                                if (len_eff != '0) state_q <= S_XOR;
                            end
                            OP_REFRESH: begin
                                if (len_eff != '0) state_q <= S_REFRESH;
                            end
                            OP_CLEAR: begin
                                last_q  <= AW'(NUM_REGS - 1);
                                state_q <= S_CLEAR;
                            end
                            default: ;
                        endcase
                    end
                end
                S_XOR: begin
                    mem[dst] <= mem[dst] ^ mem[src];
                    cnt_q    <= cnt_q + AW'(1);
                    if (cnt_q == last_q) state_q <= S_DONE;
                end
                S_REFRESH: begin
                    if (rnd_valid_i) begin
                        mem[dst] <= refreshed;
                        cnt_q    <= cnt_q + AW'(1);
                        if (cnt_q == last_q) state_q <= S_DONE;
                    end
                end
                S_CLEAR: begin
                    mem[cnt_q] <= '0;
                    cnt_q      <= cnt_q + AW'(1);
                    if (cnt_q == last_q) state_q <= S_DONE;
                end
                S_DONE:  state_q <= IDLE;
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_masked_share_rf.sv
// Directed and randomized bench for masked_share_rf against an array-based reference model.
module tb_masked_share_rf;
    import masked_rf_pkg::*;

    localparam int DW = 64;
    localparam int NR = 16;
    localparam int AW = 4;
    localparam int LW = 5;
    localparam int EW = 2 * DW;

    logic          clk = 1'b0;
    logic          rst;
    logic          req_valid;
    logic          req_ready;
    logic [2:0]    op;
    logic [AW-1:0] rd, rs1, rs2;
    logic [LW-1:0] len;
    logic [EW-1:0] wdata;
    logic [DW-1:0] rnd;
    logic          rnd_valid;
    logic          rnd_ready;
    logic [EW-1:0] rdata0, rdata1;
    logic          done;
    logic          busy;

    always #5 clk = ~clk;

    masked_share_rf #(.DATA_W(DW), .NUM_REGS(NR), .NUM_SHARES(2)) dut (
        .clk_i       (clk),
        .rst_i       (rst),
        .req_valid_i (req_valid),
        .req_ready_o (req_ready),
        .op_i        (op),
        .rd_i        (rd),
        .rs1_i       (rs1),
        .rs2_i       (rs2),
        .len_i       (len),
        .wdata_i     (wdata),
        .rnd_i       (rnd),
        .rnd_valid_i (rnd_valid),
        .rnd_ready_o (rnd_ready),
        .rdata0_o    (rdata0),
        .rdata1_o    (rdata1),
        .done_o      (done),
        .busy_o      (busy)
    );

    logic [EW-1:0] model [NR];
    int checks = 0;
    int errors = 0;

    task automatic chk(input string tag, input logic [EW-1:0] obs, input logic [EW-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [EW-1:0] mk(input logic [DW-1:0] s1, input logic [DW-1:0] s0);
        return {s1, s0};
    endfunction

    // Called at a negedge with the DUT idle; returns at the negedge of the first cycle after accept.
    task automatic issue(input logic [2:0] o, input int a_rd, input int a_rs1, input int a_rs2,
                         input int a_len, input logic [EW-1:0] wd);
        chk("req_ready_before_issue", EW'(req_ready), EW'(1));
        req_valid = 1'b1;
        op        = o;
        rd        = a_rd[AW-1:0];
        rs1       = a_rs1[AW-1:0];
        rs2       = a_rs2[AW-1:0];
        len       = a_len[LW-1:0];
        wdata     = wd;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        op        = 3'($urandom);
        rd        = AW'($urandom);
        rs1       = AW'($urandom);
        rs2       = AW'($urandom);
        len       = LW'($urandom);
        wdata     = {$urandom, $urandom, $urandom, $urandom};
    endtask

    // n = cycle index (1 = first cycle after accept) where done was seen; ends back in IDLE.
    task automatic wait_done(output int n);
        n = 0;
        repeat (200) begin
            n++;
            if (done === 1'b1) begin
                @(negedge clk);
                return;
            end
            @(negedge clk);
        end
        checks++;
        errors++;
        $error("FAIL done_timeout: observed no done within 200 cycles, expected a done pulse");
        n = -1;
    endtask

    task automatic read_entry(input int a, output logic [EW-1:0] d);
        int n;
        issue(OP_READ, 0, a, a, 0, '0);
        wait_done(n);
        d = rdata0;
    endtask

    task automatic check_all(input string tag);
        logic [EW-1:0] d;
        for (int i = 0; i < NR; i++) begin
            read_entry(i, d);
            chk($sformatf("%s_entry%0d", tag, i), d, model[i]);
        end
    endtask

    task automatic model_xor(input int a_rd, input int a_rs1, input int a_len);
        int l;
        l = (a_len > NR) ? NR : a_len;
        for (int i = 0; i < l; i++) begin
            model[(a_rd + i) % NR] ^= model[(a_rs1 + i) % NR];
        end
    endtask

    task automatic do_write(input int a, input logic [EW-1:0] d);
        int n;
        issue(OP_WRITE, a, 0, 0, 0, d);
        wait_done(n);
        model[a] = d;
    endtask

    // Random stalls on rnd_valid; the model advances only on cycles it offers randomness.
    task automatic do_refresh(input int a_rd, input int a_len);
        int l, k, guard;
        logic [DW-1:0] r;
        l = (a_len > NR) ? NR : a_len;
        k = 0;
        guard = 0;
        issue(OP_REFRESH, a_rd, 0, 0, a_len, '0);
        while (k < l && guard < 300) begin
            guard++;
            chk("refresh_rnd_ready", EW'(rnd_ready), EW'(1));
            rnd_valid = 1'($urandom_range(0, 1));
            r = {$urandom, $urandom};
            rnd = r;
            if (rnd_valid) begin
                model[(a_rd + k) % NR] ^= {r, r};
                k++;
            end
            @(negedge clk);
        end
        rnd_valid = 1'b0;
        chk("refresh_done_after_last", EW'(done), EW'(1));
        @(negedge clk);
    endtask

    initial begin
        int n, seen_done, bad_ready;
        logic [EW-1:0] d, e4, e5;

        rst = 1'b1; req_valid = 1'b0; op = '0; rd = '0; rs1 = '0; rs2 = '0;
        len = '0; wdata = '0; rnd = '0; rnd_valid = 1'b0;
        for (int i = 0; i < NR; i++) model[i] = '0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        #1;
        chk("reset_busy", EW'(busy), EW'(0));
        chk("reset_done", EW'(done), EW'(0));
        chk("reset_rnd_ready", EW'(rnd_ready), EW'(0));
        chk("reset_req_ready", EW'(req_ready), EW'(1));
        chk("reset_rdata0", rdata0, '0);
        chk("reset_rdata1", rdata1, '0);
        @(negedge clk);

        // WRITE then READ; req_ready must be low in the done cycle.
        issue(OP_WRITE, 3, 0, 0, 0, mk(64'hFFFF0000FFFF0000, 64'h0123456789ABCDEF));
        model[3] = mk(64'hFFFF0000FFFF0000, 64'h0123456789ABCDEF);
        chk("write_done_next_cycle", EW'(done), EW'(1));
        chk("write_ready_low_in_done", EW'(req_ready), EW'(0));
        @(negedge clk);
        issue(OP_READ, 0, 3, 0, 0, '0);
        chk("read_done_next_cycle", EW'(done), EW'(1));
        chk("read_rdata0", rdata0, model[3]);
        chk("read_rdata1", rdata1, '0);
        @(negedge clk);

        // REFRESH with a 3-cycle randomness gap.
        do_write(4, mk(64'h55, 64'hAA));
        do_write(5, mk(64'hF0, 64'h0F));
        issue(OP_REFRESH, 4, 0, 0, 2, '0);
        seen_done = 0;
        for (int c = 1; c <= 5; c++) begin
            chk($sformatf("refresh_rnd_ready_c%0d", c), EW'(rnd_ready), EW'(1));
            if (done) seen_done++;
            rnd_valid = (c == 1 || c == 5);
            rnd = (c == 1) ? 64'h11 : 64'h22;
            @(negedge clk);
        end
        rnd_valid = 1'b0;
        chk("refresh_no_early_done", EW'(seen_done), EW'(0));
        chk("refresh_done_5_after_first", EW'(done), EW'(1));
        @(negedge clk);
        model[4] = mk(64'h44, 64'hBB);
        model[5] = mk(64'hD2, 64'h2D);
        read_entry(4, e4);
        read_entry(5, e5);
        chk("refresh_entry4", e4, model[4]);
        chk("refresh_entry5", e5, model[5]);
        chk("refresh_unmasked4", EW'(e4[DW-1:0] ^ e4[EW-1:DW]), EW'(64'hFF));
        chk("refresh_unmasked5", EW'(e5[DW-1:0] ^ e5[EW-1:DW]), EW'(64'hFF));

        // XOR with wrap-around and overlapping ranges.
        for (int i = 0; i < 4; i++) do_write(i, EW'(i + 1));
        do_write(14, EW'(8'h10));
        do_write(15, EW'(8'h20));
        issue(OP_XOR, 14, 0, 0, 4, '0);
        wait_done(n);
        chk("xor_latency", EW'(n), EW'(5));
        model_xor(14, 0, 4);
        chk("xor_model_e14", model[14], EW'(8'h11));
        chk("xor_model_e1", model[1], EW'(6));
        check_all("xor_wrap");

        // SWAP, self-SWAP and zero-length XOR.
        issue(OP_SWAP, 0, 2, 5, 0, '0);
        wait_done(n);
        chk("swap_latency", EW'(n), EW'(1));
        d = model[2]; model[2] = model[5]; model[5] = d;
        issue(OP_SWAP, 0, 2, 2, 0, '0);
        wait_done(n);
        issue(OP_XOR, 7, 2, 0, 0, '0);
        wait_done(n);
        chk("xor_len0_latency", EW'(n), EW'(1));
        issue(3'd7, 0, 0, 0, 0, '0);
        wait_done(n);
        chk("undef_op_latency", EW'(n), EW'(1));
        check_all("swap");

        // Commands and randomness offered while busy are ignored.
        issue(OP_XOR, 8, 9, 0, 3, '0);
        model_xor(8, 9, 3);
        bad_ready = 0;
        n = 0;
        while (done !== 1'b1 && n < 50) begin
            n++;
            req_valid = 1'b1; op = OP_WRITE; rd = 4'd9; wdata = '1;
            rnd_valid = ~rnd_valid;
            if (req_ready || rnd_ready) bad_ready++;
            @(negedge clk);
        end
        if (req_ready || rnd_ready) bad_ready++;
        req_valid = 1'b0; rnd_valid = 1'b0;
        chk("busy_no_ready", EW'(bad_ready), EW'(0));
        chk("busy_xor_cycles", EW'(n), EW'(3));
        @(negedge clk);
        check_all("busy");

        // Randomized mix against the model, including over-long lengths.
        for (int t = 0; t < 40; t++) begin
            int k, a, b, l;
            k = $urandom_range(0, 3);
            a = $urandom_range(0, NR - 1);
            b = $urandom_range(0, NR - 1);
            l = $urandom_range(0, 31);
            case (k)
                0: do_write(a, {$urandom, $urandom, $urandom, $urandom});
                1: begin
                    issue(OP_XOR, a, b, 0, l, '0);
                    wait_done(n);
                    model_xor(a, b, l);
                    chk("rand_xor_latency", EW'(n), EW'(((l > NR) ? NR : l) + 1));
                end
                2: do_refresh(a, l);
                default: begin
                    issue(OP_SWAP, 0, a, b, 0, '0);
                    wait_done(n);
                    d = model[a]; model[a] = model[b]; model[b] = d;
                end
            endcase
        end
        check_all("random");

        // Reset at element 1 of a CLEAR aborts it and wipes everything.
        issue(OP_CLEAR, 0, 0, 0, 0, '0);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("abort_busy", EW'(busy), EW'(0));
        chk("abort_req_ready", EW'(req_ready), EW'(1));
        chk("abort_rdata0", rdata0, '0);
        seen_done = 0;
        repeat (20) begin
            if (done) seen_done++;
            @(negedge clk);
        end
        chk("abort_no_done", EW'(seen_done), EW'(0));
        for (int i = 0; i < NR; i++) model[i] = '0;
        check_all("abort");

        // Full CLEAR after refilling.
        for (int i = 0; i < NR; i++) do_write(i, {$urandom, $urandom, $urandom, $urandom});
        issue(OP_CLEAR, 0, 0, 0, 3, '0);
        wait_done(n);
        chk("clear_latency", EW'(n), EW'(NR + 1));
        for (int i = 0; i < NR; i++) model[i] = '0;
        check_all("clear");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/masked_share_rf.md
Name: masked_share_rf

Overview:
- Parametrised, sequenced register file holding AES state and round keys as Boolean-masked shares for the masked crypto datapath in the CVA6 core.
- Each entry stores NUM_SHARES shares of DATA_W bits. Every register holds both shares of a value at one address.
- Multi-register operations run as a hardware sequence, one entry per cycle, under a valid/ready command handshake:
  - share-wise XOR (add-round-key)
  - remasking from a randomness stream
  - swap
  - zeroisation

Parameters:
- DATA_W, 64, width of one share.
- NUM_REGS, 16, number of entries; power of two, at least 4.
- NUM_SHARES, 2, shares per entry; at least 2.
- AW, $clog2(NUM_REGS), address width (derived).
- LW, AW+1, width of the length field (derived).

Ports:
- clk_i  in  1  clock.
- rst_i  in  1  synchronous, active-high reset.
- req_valid_i  in  1  command valid.
- req_ready_o  out  1  command accepted when high together with req_valid_i.
- op_i  in  3  opcode (masked_rf_pkg::op_e).
- rd_i  in  AW  destination base address.
- rs1_i  in  AW  source-1 base address.
- rs2_i  in  AW  source-2 address (SWAP only).
- len_i  in  LW  entry count for XOR and REFRESH, range 0..NUM_REGS.
- wdata_i  in  NUM_SHARES*DATA_W  write data; share s occupies bits [s*DATA_W +: DATA_W].
- rnd_i  in  (NUM_SHARES-1)*DATA_W  fresh randomness.
- rnd_valid_i  in  1  rnd_i valid.
- rnd_ready_o  out  1  rnd_i consumed this cycle.
- rdata0_o  out  NUM_SHARES*DATA_W  read data for rs1.
- rdata1_o  out  NUM_SHARES*DATA_W  read data for rs2.
- done_o  out  1  one-cycle pulse when a command completes.
- busy_o  out  1  FSM not in IDLE.

Behaviour:
- Reset (rst_i=1 at a clock edge):
  - FSM goes to IDLE and all entries are cleared to 0.
  - rdata0_o/rdata1_o = 0; done_o = 0; rnd_ready_o = 0; busy_o = 0.
  - Reset overrides any operation in progress; no partial result survives.
- Handshake:
  - req_ready_o = (state==IDLE) && !rst_i.
  - Command fields are captured on acceptance; later changes to the inputs are ignored.
- Addresses:
  - Element i of a sequence uses (base+i) mod NUM_REGS, so addresses wrap around.
  - Reads in each cycle see the contents committed by earlier elements (sequential semantics). Overlapping source and destination ranges are therefore legal and deterministic.
- OP_WRITE: entry[rd_i] <= wdata_i in the accept cycle; done_o pulses in the next cycle.
- OP_READ:
  - rdata0_o <= entry[rs1_i] and rdata1_o <= entry[rs2_i], registered; done_o pulses in the same cycle the data appears.
  - rdata0_o/rdata1_o hold until the next READ or reset.
- OP_SWAP: entry[rs1_i] and entry[rs2_i] are exchanged in the accept cycle. rs1_i==rs2_i leaves the entry unchanged. done_o pulses in the next cycle.
- OP_XOR (state S_XOR):
  - Per cycle, element i: share s of entry[rd+i] ^= share s of entry[rs1+i], for all s.
  - Takes len_i cycles; done_o pulses in the cycle after the last element.
- OP_REFRESH (state S_REFRESH):
  - Per element: rnd_ready_o=1. The element commits only in a cycle where rnd_valid_i=1.
  - Shares s < NUM_SHARES-1: share s ^= rnd_i[s].
  - Last share ^= XOR-reduction of all rnd_i words, so the XOR of the shares (the unmasked value) is unchanged.
  - When rnd_valid_i=0 the FSM stalls with no write.
  - Latency = len_i + stall cycles; done_o pulses after the last commit.
- OP_CLEAR (state S_CLEAR): zeroes entries 0..NUM_REGS-1, one per cycle, ignoring len_i. Takes NUM_REGS cycles, then done_o pulses.
- len_i==0 for XOR/REFRESH: no writes; done_o pulses in the cycle after accept.
- len_i > NUM_REGS: clamped to NUM_REGS.
- Undefined opcode: accepted as a no-op; done_o pulses in the next cycle.
- rnd_ready_o = 1 only in S_REFRESH; rnd_i is never consumed in any other state.
- FSM states: IDLE, S_XOR, S_REFRESH, S_CLEAR, S_DONE.
  - IDLE -> S_XOR, S_REFRESH or S_CLEAR on a multi-cycle accept; IDLE -> S_DONE for single-cycle ops or len_i==0.
  - Sequence states -> S_DONE when the element counter reaches len-1 and that element commits.
  - S_DONE asserts done_o and returns to IDLE.
  - Back-to-back command throughput is therefore one command per 2 cycles minimum.

Decomposition:
- masked_rf_pkg:
  - op_e: OP_WRITE, OP_READ, OP_SWAP, OP_XOR, OP_REFRESH, OP_CLEAR.
  - state_e.
  - share_t: a packed array of NUM_SHARES words of DATA_W bits.
- Sub-module masked_share_refresh: combinational; maps one entry plus rnd_i to the remasked entry. Parametrised on DATA_W and NUM_SHARES, and reusable by the S-box datapath.

Test Plan:
- WRITE rd=3 with shares {0x0123456789ABCDEF, 0xFFFF0000FFFF0000}, then READ rs1=3 rs2=0 -> rdata0_o equals the written data and rdata1_o=0. done_o pulses 1 cycle after each accept; req_ready_o is low during S_DONE.
- Write entry 4={0xAA,0x55} and entry 5={0x0F,0xF0}. REFRESH rd=4 len=2 with rnd 0x11 then 0x22, with rnd_valid_i low for 3 cycles between them -> entry4={0xBB,0x44} and entry5={0x2D,0xD2}. The share XOR stays 0xFF for both. done_o arrives exactly 5 cycles after the first element cycle.
- Entries 0..3 hold 1..4 (share 0), 14/15 hold 0x10/0x20. XOR rd=14 rs1=0 len=4 -> entry14=0x11, entry15=0x22, entry0=1^3=2, entry1=2^4=6. This checks wrap-around and the sequential overlap rule.
- SWAP rs1=2 rs2=5 -> contents exchanged. SWAP rs1=2 rs2=2 -> no change. XOR len=0 -> no writes, done_o in the cycle after accept.
- Assert rst_i in the middle of a CLEAR or REFRESH, at element 1 -> on the next cycle all entries read 0, busy_o=0, req_ready_o=1, done_o never pulses for the aborted command.
- Drive req_valid_i while busy_o=1 -> no acceptance and state untouched. rnd_valid_i toggling outside REFRESH -> rnd_ready_o stays 0.
